// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with byte-enable writes, programmable wait states,
// a memory-mapped tohost register and out-of-range detection.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        addr_err,
  output logic [31:0] tohost
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] din_q, din_d;
  logic        re_q, re_d;
  logic [31:0] dout_q, dout_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] tohost_q, tohost_d;

  logic [31:0] mem_q [0:DEPTH-1];

  logic                  req;
  logic                  complete;
  logic [29:0]           eff_wa;
  logic [3:0]            eff_we;
  logic [31:0]           eff_din;
  logic                  eff_re;
  logic                  is_tohost;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic                  mem_wr;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^dcache_addr[1:0];
  assign req = dcache_re | (|dcache_we);

  // In IDLE a zero-latency access completes straight from the live inputs;
  // in BUSY the captured request is the one being serviced.
  assign eff_wa  = (state_q == IDLE) ? dcache_addr[31:2] : addr_q;
  assign eff_we  = (state_q == IDLE) ? dcache_we         : we_q;
  assign eff_din = (state_q == IDLE) ? dcache_din        : din_q;
  assign eff_re  = (state_q == IDLE) ? dcache_re         : re_q;

  assign is_tohost    = (eff_wa == TOHOST_ADDR[31:2]);
  assign out_of_range = !is_tohost && (eff_wa[29:ADDR_WIDTH] != '0);
  assign idx          = eff_wa[ADDR_WIDTH-1:0];
  assign rd_word      = is_tohost ? tohost_q : (out_of_range ? 32'd0 : mem_q[idx]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    din_d      = din_q;
    re_d       = re_q;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = dcache_addr[31:2];
          we_d   = dcache_we;
          din_d  = dcache_din;
          re_d   = dcache_re;
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d     = dout_q;
    addr_err_d = complete && out_of_range;
    tohost_d   = tohost_q;
    if (complete && eff_re) dout_d = rd_word;
    if (complete && is_tohost) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_we[i]) tohost_d[8*i +: 8] = eff_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      din_q      <= '0;
      re_q       <= 1'b0;
      dout_q     <= '0;
      addr_err_q <= 1'b0;
      tohost_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      re_q       <= re_d;
      dout_q     <= dout_d;
      addr_err_q <= addr_err_d;
      tohost_q   <= tohost_d;
    end
  end

  // Gated by reset_n so a request dropped by reset never reaches the array.
  assign mem_wr = complete && reset_n && !is_tohost && !out_of_range;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_we[i]) mem_q[idx][8*i +: 8] <= eff_din[8*i +: 8];
      end
    end
  end

  assign dcache_dout = dout_q;
  assign stall       = (state_q == BUSY);
  assign addr_err    = addr_err_q;
  assign tohost      = tohost_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 0, 2 and 3 share one clock.
module tb_dmem_responder;

  logic              clk;
  logic [2:0]        rst_n;
  logic [31:0]       addr [3];
  logic              re   [3];
  logic [3:0]        we   [3];
  logic [31:0]       din  [3];
  logic [2:0][31:0]  dout;
  logic [2:0]        stall;
  logic [2:0]        aerr;
  logic [2:0][31:0]  tohost;

  int checks = 0;
  int errors = 0;
  int sc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .dcache_addr(addr[0]), .dcache_re(re[0]),
    .dcache_we(we[0]), .dcache_din(din[0]), .dcache_dout(dout[0]),
    .stall(stall[0]), .addr_err(aerr[0]), .tohost(tohost[0]));

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut2 (
    .clk(clk), .reset_n(rst_n[1]), .dcache_addr(addr[1]), .dcache_re(re[1]),
    .dcache_we(we[1]), .dcache_din(din[1]), .dcache_dout(dout[1]),
    .stall(stall[1]), .addr_err(aerr[1]), .tohost(tohost[1]));

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (
    .clk(clk), .reset_n(rst_n[2]), .dcache_addr(addr[2]), .dcache_re(re[2]),
    .dcache_we(we[2]), .dcache_din(din[2]), .dcache_dout(dout[2]),
    .stall(stall[2]), .addr_err(aerr[2]), .tohost(tohost[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request, releases it right after the accept edge, then waits
  // (bounded) for stall to drop. Returns at accept/complete edge + 1.
  task automatic access(input int d, input logic [31:0] a, input logic r,
                        input logic [3:0] w, input logic [31:0] di, output int stall_cycles);
    @(negedge clk);
    addr[d] = a; re[d] = r; we[d] = w; din[d] = di;
    @(posedge clk); #1;
    re[d] = 1'b0; we[d] = 4'h0;
    stall_cycles = 0;
    while (stall[d] && stall_cycles < 40) begin
      @(posedge clk); #1;
      stall_cycles++;
    end
    if (stall_cycles >= 40) check("stall_timeout", 32'(stall[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; re[i] = 1'b0; we[i] = 4'h0; din[i] = '0;
    end
    rst_n = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_dout",   dout[i],          32'd0);
      check("rst_stall",  32'(stall[i]),    32'd0);
      check("rst_aerr",   32'(aerr[i]),     32'd0);
      check("rst_tohost", tohost[i],        32'd0);
    end
    @(negedge clk);
    rst_n = 3'b111;

    // LATENCY=0 write then read
    access(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF, sc);
    check("l0_wr_stall", 32'(sc), 32'd0);
    check("l0_wr_dout_hold", dout[0], 32'd0);
    access(0, 32'h10, 1'b1, 4'h0, 32'h0, sc);
    check("l0_rd_stall", 32'(sc), 32'd0);
    check("l0_rd_dout", dout[0], 32'hDEADBEEF);

    // partial write
    access(0, 32'h14, 1'b0, 4'hF, 32'h11223344, sc);
    access(0, 32'h14, 1'b0, 4'b0101, 32'hAABBCCDD, sc);
    check("partial_dout_hold", dout[0], 32'hDEADBEEF);
    access(0, 32'h14, 1'b1, 4'h0, 32'h0, sc);
    check("partial_rd", dout[0], 32'h11BB33DD);

    // read-before-write on a combined access
    access(0, 32'h14, 1'b1, 4'hF, 32'h0BADF00D, sc);
    check("rbw_old", dout[0], 32'h11BB33DD);
    access(0, 32'h14, 1'b1, 4'h0, 32'h0, sc);
    check("rbw_new", dout[0], 32'h0BADF00D);

    // tohost
    access(0, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D, sc);
    access(0, 32'h8000_0000, 1'b0, 4'hF, 32'h1, sc);
    check("tohost_val", tohost[0], 32'h1);
    access(0, 32'h0, 1'b1, 4'h0, 32'h0, sc);
    check("tohost_mem0", dout[0], 32'hCAFEF00D);
    access(0, 32'h8000_0000, 1'b1, 4'h0, 32'h0, sc);
    check("tohost_rd", dout[0], 32'h1);
    access(0, 32'h8000_0000, 1'b0, 4'b0010, 32'h0000AB00, sc);
    check("tohost_merge", tohost[0], 32'h0000AB01);

    // out of range
    access(0, 32'h4000, 1'b1, 4'h0, 32'h0, sc);
    check("oor_rd_dout", dout[0], 32'd0);
    check("oor_rd_aerr", 32'(aerr[0]), 32'd1);
    @(posedge clk); #1;
    check("oor_aerr_pulse", 32'(aerr[0]), 32'd0);
    access(0, 32'h4000, 1'b0, 4'hF, 32'h77777777, sc);
    check("oor_wr_aerr", 32'(aerr[0]), 32'd1);
    access(0, 32'h0, 1'b1, 4'h0, 32'h0, sc);
    check("oor_wr_nowrap", dout[0], 32'hCAFEF00D);
    check("oor_aerr_clr", 32'(aerr[0]), 32'd0);
    access(0, 32'h3FFC, 1'b0, 4'hF, 32'h13579BDF, sc);
    check("last_wr_aerr", 32'(aerr[0]), 32'd0);
    access(0, 32'h3FFC, 1'b1, 4'h0, 32'h0, sc);
    check("last_rd", dout[0], 32'h13579BDF);
    check("last_rd_aerr", 32'(aerr[0]), 32'd0);

    // LATENCY=2
    access(1, 32'h20, 1'b0, 4'hF, 32'h0A0B0C0D, sc);
    check("l2_wr_stall", 32'(sc), 32'd2);
    access(1, 32'h24, 1'b0, 4'hF, 32'h24242424, sc);
    @(negedge clk);
    addr[1] = 32'h20; re[1] = 1'b1; we[1] = 4'h0;
    @(posedge clk); #1;
    check("l2_stall_accept", 32'(stall[1]), 32'd1);
    addr[1] = 32'h24; re[1] = 1'b0; we[1] = 4'hF; din[1] = 32'hFFFFFFFF;
    sc = 0;
    while (stall[1] && sc < 40) begin
      @(posedge clk); #1;
      sc++;
    end
    re[1] = 1'b0; we[1] = 4'h0;
    check("l2_rd_stall", 32'(sc), 32'd2);
    check("l2_rd_dout", dout[1], 32'h0A0B0C0D);
    access(1, 32'h24, 1'b1, 4'h0, 32'h0, sc);
    check("l2_ignored_req", dout[1], 32'h24242424);

    // LATENCY=3 with reset mid-write
    access(2, 32'h40, 1'b0, 4'hF, 32'h5555AAAA, sc);
    check("l3_wr_stall", 32'(sc), 32'd3);
    access(2, 32'h40, 1'b1, 4'h0, 32'h0, sc);
    check("l3_rd_dout", dout[2], 32'h5555AAAA);
    @(negedge clk);
    addr[2] = 32'h40; we[2] = 4'hF; din[2] = 32'h12345678;
    @(posedge clk); #1;
    we[2] = 4'h0;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("l3_rst_stall", 32'(stall[2]), 32'd0);
    check("l3_rst_dout", dout[2], 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    access(2, 32'h40, 1'b1, 4'h0, 32'h0, sc);
    check("l3_rst_dropped", dout[2], 32'h5555AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
